mem_port_arbiter: RTL

//  Shares one single-ported memory bus between IF (instruction fetch, read-only) and MEM (load/store).

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// DATA_WIDTH falls back to 32 when no project-wide define is present.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_MEM_WAIT,
      ARB_IF_WAIT,
      ARB_RESP
   } arb_state_t;

   typedef enum logic {
      GRANT_IF,
      GRANT_MEM
   } arb_grant_t;

   localparam int ARB_DATA_WIDTH = `DATA_WIDTH;
   localparam int ARB_ADDR_WIDTH = 32;

   // Requester that wins a simultaneous request: whoever was not served last.
   function automatic arb_grant_t arb_other(input arb_grant_t g);
      return (g == GRANT_IF) ? GRANT_MEM : GRANT_IF;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Wait-cycle counter for a bus transaction; flags expiry when the count reaches LIMIT.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   assign expired = (count_reg == CW'(LIMIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (tick && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/ack memory bus between IF (read-only) and MEM.
// Optional per-transaction timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic [DATA_WIDTH-1:0] o_if_rdata,
   output logic                  o_if_done,
   input  logic                  i_mem_req,
   input  logic                  i_mem_we,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_wdata,
   output logic [DATA_WIDTH-1:0] o_mem_rdata,
   output logic                  o_mem_done,
   output logic                  o_stall_if,
   output logic                  o_stall_mem,
   output logic                  o_bus_req,
   output logic                  o_bus_we,
   output logic [ADDR_WIDTH-1:0] o_bus_addr,
   output logic [DATA_WIDTH-1:0] o_bus_wdata,
   input  logic                  i_bus_ack,
   input  logic [DATA_WIDTH-1:0] i_bus_rdata,
   output logic                  o_bus_err
);

   arb_state_t state_reg;
   arb_grant_t last_grant_reg;
   logic       in_wait;
   logic       timeout_hit;

   assign in_wait     = (state_reg == ARB_MEM_WAIT) || (state_reg == ARB_IF_WAIT);
   assign o_stall_if  = i_if_req  & ~o_if_done;
   assign o_stall_mem = i_mem_req & ~o_mem_done;

`ifdef ARB_TIMEOUT_EN
   mem_arb_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_reg == ARB_IDLE),
      .tick    (in_wait && !i_bus_ack),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ARB_IDLE;
         last_grant_reg <= GRANT_IF;
         o_if_rdata     <= '0;
         o_if_done      <= 1'b0;
         o_mem_rdata    <= '0;
         o_mem_done     <= 1'b0;
         o_bus_req      <= 1'b0;
         o_bus_we       <= 1'b0;
         o_bus_addr     <= '0;
         o_bus_wdata    <= '0;
         o_bus_err      <= 1'b0;
      end else begin
         o_if_done  <= 1'b0;
         o_mem_done <= 1'b0;
         o_bus_err  <= 1'b0;
         case (state_reg)
            ARB_IDLE: begin
               if (i_mem_req && (!i_if_req || arb_other(last_grant_reg) == GRANT_MEM)) begin
                  state_reg      <= ARB_MEM_WAIT;
                  last_grant_reg <= GRANT_MEM;
                  o_bus_req      <= 1'b1;
                  o_bus_we       <= i_mem_we;
                  o_bus_addr     <= i_mem_addr;
                  o_bus_wdata    <= i_mem_wdata;
               end else if (i_if_req) begin
                  state_reg      <= ARB_IF_WAIT;
                  last_grant_reg <= GRANT_IF;
                  o_bus_req      <= 1'b1;
                  o_bus_we       <= 1'b0;
                  o_bus_addr     <= i_if_addr;
                  o_bus_wdata    <= '0;
               end
            end
            ARB_MEM_WAIT, ARB_IF_WAIT: begin
               // Ack takes priority over an expiry in the same cycle.
               if (i_bus_ack || timeout_hit) begin
                  state_reg <= ARB_RESP;
                  o_bus_req <= 1'b0;
                  o_bus_err <= ~i_bus_ack;
                  if (state_reg == ARB_MEM_WAIT) begin
                     o_mem_done  <= 1'b1;
                     o_mem_rdata <= i_bus_ack ? i_bus_rdata : '0;
                  end else begin
                     o_if_done  <= 1'b1;
                     o_if_rdata <= i_bus_ack ? i_bus_rdata : '0;
                  end
               end
            end
            ARB_RESP: begin
               state_reg <= ARB_IDLE;
            end
            default: begin
               state_reg <= ARB_IDLE;
               o_bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
